// File: rtl/ps2_receiver_pkg.sv
// Shared PS/2 receiver definitions: frame layout, FSM states and
// common scan-code prefixes used by the downstream key decoder.
package ps2_receiver_pkg;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_SC_BREAK = 8'hF0;
    localparam logic [7:0] PS2_SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_e;

    // Bits after the start bit, in arrival order from LSB.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_receiver_sync_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample glitch filter for one
// PS/2 pin; fall_o pulses for one cycle when the filtered level drops.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic          fall_q;
    logic          fall_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter runs only while the synced sample disagrees with the level.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= pin_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_receiver.sv
// Host-side PS/2 device-to-host frame receiver: deframes 11-bit frames
// and hands scan-code bytes to a valid/ready consumer.
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overrun,
    output logic       err_timeout
);

    localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    logic clk_level_unused;
    logic clk_fall;
    logic dat_level;
    logic dat_fall_unused;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (ps2_clk),
        .level_o(clk_level_unused),
        .fall_o (clk_fall)
    );

    ps2_sync_filter #(
        .FILTER_LEN(1)
    ) u_dat_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (ps2_dat),
        .level_o(dat_level),
        .fall_o (dat_fall_unused)
    );

    ps2_state_e      state_q;
    ps2_state_e      state_d;
    logic [9:0]      sh_q;
    logic [9:0]      sh_d;
    logic [3:0]      bit_cnt_q;
    logic [3:0]      bit_cnt_d;
    logic [TO_W-1:0] to_q;
    logic [TO_W-1:0] to_d;
    logic [7:0]      rx_data_q;
    logic [7:0]      rx_data_d;
    logic            rx_valid_q;
    logic            rx_valid_d;
    logic            err_parity_q;
    logic            err_parity_d;
    logic            err_frame_q;
    logic            err_frame_d;
    logic            err_overrun_q;
    logic            err_overrun_d;
    logic            err_timeout_q;
    logic            err_timeout_d;

    ps2_frame_t frame;
    logic       accept;

    assign frame  = sh_q;
    assign accept = rx_valid_q & rx_ready;

    always_comb begin
        state_d       = state_q;
        sh_d          = sh_q;
        bit_cnt_d     = bit_cnt_q;
        to_d          = to_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~accept;
        err_parity_d  = 1'b0;
        err_frame_d   = 1'b0;
        err_overrun_d = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (clk_fall) begin
                    if (!dat_level) begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = 4'd1;
                        to_d      = '0;
                        sh_d      = '0;
                    end else begin
                        err_frame_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    sh_d = {dat_level, sh_q[9:1]};
                    to_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d       = ST_IDLE;
                    err_timeout_d = 1'b1;
                    sh_d          = '0;
                    bit_cnt_d     = '0;
                    to_d          = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_CHECK: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                // A byte accepted this cycle frees the slot for the new one.
                if (!frame.stop) begin
                    err_frame_d = 1'b1;
                end else if (!odd_parity_ok({frame.parity, frame.data})) begin
                    err_parity_d = 1'b1;
                end else if (rx_valid_q && !rx_ready) begin
                    err_overrun_d = 1'b1;
                end else begin
                    rx_data_d  = frame.data;
                    rx_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sh_q          <= '0;
            bit_cnt_q     <= '0;
            to_q          <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            bit_cnt_q     <= bit_cnt_d;
            to_q          <= to_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;

endmodule
